// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning all HI/LO writes (shift-add multiply, restoring divide).
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU behave as reserved no-ops.
`timescale 1ns/1ps
module muldiv_ctrl #(
  parameter logic [31:0] DIV0_HI = 32'h0000_0000,
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        cancel,
  input  logic        hiloRead,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] dinHi,
  output logic [31:0] dinLo,
  output logic [1:0]  hlWrite
);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WB} stateT;

  stateT       stateReg, stateNext;
  logic [4:0]  countReg, countNext;
  logic [2:0]  opReg, opNext;
  logic [31:0] hiReg, hiNext;
  logic [31:0] loReg, loNext;
  logic [31:0] opndReg, opndNext;
  logic        negResReg, negResNext;

  logic        signedOp;
  logic [31:0] absA, absB;
  logic [32:0] mulSum;

`ifdef MULDIV_DIV_EN
  logic        negRemReg, negRemNext;
  logic [32:0] divShift;
  logic [33:0] divDiff;
`else
  wire [63:0] unusedDiv0 = {DIV0_HI, DIV0_LO};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateReg  <= IDLE;
      countReg  <= 5'd0;
      opReg     <= 3'd0;
      hiReg     <= 32'd0;
      loReg     <= 32'd0;
      opndReg   <= 32'd0;
      negResReg <= 1'b0;
`ifdef MULDIV_DIV_EN
      negRemReg <= 1'b0;
`endif
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      opReg     <= opNext;
      hiReg     <= hiNext;
      loReg     <= loNext;
      opndReg   <= opndNext;
      negResReg <= negResNext;
`ifdef MULDIV_DIV_EN
      negRemReg <= negRemNext;
`endif
    end
  end

  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    opNext     = opReg;
    hiNext     = hiReg;
    loNext     = loReg;
    opndNext   = opndReg;
    negResNext = negResReg;
    busy       = (stateReg != IDLE);
    done       = 1'b0;
    hlWrite    = 2'b00;
    dinHi      = 32'd0;
    dinLo      = 32'd0;
    // Signed variants are the even opcodes (MULT, DIV).
    signedOp   = ~op[0];
    absA       = (signedOp && srcA[31]) ? (32'd0 - srcA) : srcA;
    absB       = (signedOp && srcB[31]) ? (32'd0 - srcB) : srcB;
    mulSum     = {1'b0, hiReg} + {1'b0, opndReg};
`ifdef MULDIV_DIV_EN
    negRemNext = negRemReg;
    divShift   = {hiReg, loReg[31]};
    divDiff    = {1'b0, divShift} - {2'b00, opndReg};
`endif

    case (stateReg)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              opNext     = op;
              hiNext     = 32'd0;
              loNext     = absB;
              opndNext   = absA;
              negResNext = signedOp & (srcA[31] ^ srcB[31]);
              countNext  = 5'd0;
              stateNext  = MUL;
            end
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
              opNext = op;
              if (srcB == 32'd0) begin
                hiNext    = DIV0_HI;
                loNext    = DIV0_LO;
                stateNext = WB;
              end else begin
                hiNext     = 32'd0;
                loNext     = absA;
                opndNext   = absB;
                negResNext = signedOp & (srcA[31] ^ srcB[31]);
                negRemNext = signedOp & srcA[31];
                countNext  = 5'd0;
                stateNext  = DIV;
              end
            end
`endif
            OP_MTHI: begin
              opNext    = op;
              hiNext    = srcA;
              stateNext = WB;
            end
            OP_MTLO: begin
              opNext    = op;
              loNext    = srcA;
              stateNext = WB;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        // Right-shifting shift-add: HI accumulates, LO drains the multiplier.
        if (loReg[0]) {hiNext, loNext} = {mulSum, loReg[31:1]};
        else          {hiNext, loNext} = {1'b0, hiReg, loReg[31:1]};
        countNext = countReg + 5'd1;
        if (countReg == 5'd31) stateNext = FIX;
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        // Restoring step: HI is the partial remainder, quotient bits shift into LO.
        hiNext    = divDiff[33] ? divShift[31:0] : divDiff[31:0];
        loNext    = {loReg[30:0], ~divDiff[33]};
        countNext = countReg + 5'd1;
        if (countReg == 5'd31) stateNext = FIX;
      end
`endif
      FIX: begin
        if (!opReg[1]) begin
          if (negResReg) {hiNext, loNext} = 64'd0 - {hiReg, loReg};
        end
`ifdef MULDIV_DIV_EN
        else begin
          if (negResReg) loNext = 32'd0 - loReg;
          if (negRemReg) hiNext = 32'd0 - hiReg;
        end
`endif
        stateNext = WB;
      end
      WB: begin
        stateNext = IDLE;
        if (!cancel) begin
          done  = 1'b1;
          dinHi = hiReg;
          dinLo = loReg;
          case (opReg)
            OP_MTHI: hlWrite = 2'b10;
            OP_MTLO: hlWrite = 2'b01;
            default: hlWrite = 2'b11;
          endcase
        end
      end
      default: stateNext = IDLE;
    endcase

    if (cancel && stateReg != IDLE) stateNext = IDLE;

    stall = busy & (start | hiloRead);
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        cancel = 1'b0;
  logic        hiloRead = 1'b0;
  logic        busy, done, stall;
  logic [31:0] dinHi, dinLo;
  logic [1:0]  hlWrite;

  int nErr = 0;
  int nChk = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .cancel(cancel), .hiloRead(hiloRead), .busy(busy), .done(done), .stall(stall),
    .dinHi(dinHi), .dinLo(dinLo), .hlWrite(hlWrite)
  );

  typedef struct {
    bit          valid;
    logic [1:0]  hw;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } expT;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic and SV division semantics.
  function automatic expT model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    expT e;
    int sa, sb;
    longint la, lb, p;
    longint unsigned ua, ub, u;
    e.valid = 1'b1; e.hw = 2'b11; e.hi = 32'd0; e.lo = 32'd0; e.lat = 34;
    sa = a; sb = b;
    case (o)
      3'd0: begin la = sa; lb = sb; p = la * lb; {e.hi, e.lo} = p; end
      3'd1: begin ua = a; ub = b; u = ua * ub; {e.hi, e.lo} = u; end
      3'd2, 3'd3: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          e.hi = 32'h0000_0000; e.lo = 32'hFFFF_FFFF; e.lat = 1;
        end else if (o == 3'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = 32'd0;
          end else begin
            e.lo = sa / sb; e.hi = sa % sb;
          end
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
`else
        e.valid = 1'b0;
`endif
      end
      3'd4: begin e.hw = 2'b10; e.hi = a; e.lat = 1; end
      3'd5: begin e.hw = 2'b01; e.lo = a; e.lat = 1; end
      default: e.valid = 1'b0;
    endcase
    return e;
  endfunction

  // Entered just after a negedge with the DUT idle; leaves it idle after a negedge.
  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    expT e;
    int cyc;
    bit earlyHl;
    e = model(o, a, b);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0;
    if (!e.valid) begin
      chk("noop_busy", 64'(busy), 64'd0);
      chk("noop_hlWrite", 64'(hlWrite), 64'd0);
      chk("noop_done", 64'(done), 64'd0);
      $display("op=%0d a=%h b=%h -> no-op", o, a, b);
      return;
    end
    cyc = 1; earlyHl = 1'b0;
    while (!done && cyc < 60) begin
      if (hlWrite != 2'b00) earlyHl = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("early_hlWrite", 64'(earlyHl), 64'd0);
    chk("wb_busy", 64'(busy), 64'd1);
    chk("hlWrite", 64'(hlWrite), 64'(e.hw));
    if (e.hw[1]) chk("dinHi", 64'(dinHi), 64'(e.hi));
    if (e.hw[0]) chk("dinLo", 64'(dinLo), 64'(e.lo));
    $display("op=%0d a=%h b=%h -> hw=%b hi=%h lo=%h cycles=%0d", o, a, b, hlWrite, dinHi, dinLo, cyc);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_hlWrite", 64'(hlWrite), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    expT e;
    int cyc;
    bit sawHl;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hlWrite", 64'(hlWrite), 64'd0);
    chk("rst_dinHi", 64'(dinHi), 64'd0);
    chk("rst_dinLo", 64'(dinLo), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    doOp(3'd0, 32'hFFFF_FFFD, 32'd5);
    doOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    doOp(3'd2, 32'hFFFF_FFF9, 32'd2);
    doOp(3'd3, 32'd100, 32'd7);
    doOp(3'd3, 32'hDEAD_BEEF, 32'd0);
    doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    doOp(3'd4, 32'h1234_5678, 32'd0);
    doOp(3'd5, 32'hCAFE_F00D, 32'd0);
    doOp(3'd6, 32'd1, 32'd1);
    doOp(3'd0, 32'h8000_0000, 32'h8000_0000);

    // MFHI during MULT stalls until WB ends; a start while busy is ignored
    e = model(3'd0, 32'd1234, 32'd5678);
    start = 1'b1; op = 3'd0; srcA = 32'd1234; srcB = 32'd5678;
    @(negedge clk);
    start = 1'b0; hiloRead = 1'b1;
    chk("stall_mfhi", 64'(stall), 64'd1);
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cyc == 3) begin
        start = 1'b1; op = 3'd5; srcA = 32'h5555_5555;
        #1 chk("stall_start", 64'(stall), 64'd1);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("stall_lat", 64'(cyc), 64'(e.lat));
    chk("stall_wb", 64'(stall), 64'd1);
    chk("stall_wb_hl", 64'(hlWrite), 64'(e.hw));
    chk("stall_wb_lo", 64'(dinLo), 64'(e.lo));
    @(negedge clk);
    chk("stall_idle", 64'(stall), 64'd0);
    hiloRead = 1'b0;
    $display("op=0 a=%h b=%h with hiloRead -> stall released after WB", 32'd1234, 32'd5678);

    // Cancel at cycle 10 of MULT, MTLO accepted on the following cycle
    start = 1'b1; op = 3'd0; srcA = 32'd77; srcB = 32'd99;
    @(negedge clk);
    start = 1'b0; sawHl = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (hlWrite != 2'b00) sawHl = 1'b1;
      @(negedge clk);
    end
    cancel = 1'b1;
    #1 if (hlWrite != 2'b00) sawHl = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hl", 64'(sawHl | (hlWrite != 2'b00)), 64'd0);
    $display("op=0 cancelled at cycle 10");
    doOp(3'd5, 32'h0BAD_CAFE, 32'd0);

    // Cancel during WB gates the write
    start = 1'b1; op = 3'd4; srcA = 32'hAAAA_AAAA;
    @(negedge clk);
    start = 1'b0; cancel = 1'b1;
    #1;
    chk("cancel_wb_hl", 64'(hlWrite), 64'd0);
    chk("cancel_wb_done", 64'(done), 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_wb_busy", 64'(busy), 64'd0);
    $display("op=4 cancelled in WB");

    // Cancel in IDLE blocks acceptance
    start = 1'b1; cancel = 1'b1; op = 3'd4; srcA = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_idle_busy", 64'(busy), 64'd0);
    chk("cancel_idle_hl", 64'(hlWrite), 64'd0);
    $display("op=4 with cancel in IDLE -> not accepted");

    // Reset at cycle 20 of a long op
`ifdef MULDIV_DIV_EN
    op = 3'd3;
`else
    op = 3'd1;
`endif
    start = 1'b1; srcA = 32'd1000; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0; sawHl = 1'b0;
    for (int i = 1; i < 20; i++) begin
      if (hlWrite != 2'b00) sawHl = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hl", 64'(sawHl | (hlWrite != 2'b00)), 64'd0);
    chk("midrst_din", {dinHi, dinLo}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_after", 64'(busy), 64'd0);
    $display("op=%0d reset at cycle 20", op);

    // Random ops
    for (int n = 0; n < 24; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        default: ;
      endcase
      doOp(ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns all writes to the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage, runs an iterative 32-step shift-add multiplier or restoring divider, and drives the HI/LO write-data and write-enable inputs. Raises a pipeline stall while busy whenever a new HI/LO op or an MFHI/MFLO read is pending.

## Interface
- `DIV0_HI`, 32'h0000_0000, HI value written on divide-by-zero
- `DIV0_LO`, 32'hFFFF_FFFF, LO value written on divide-by-zero
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  op valid from execute stage
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op)
- `srcA`  in  32  rs operand (multiplicand / dividend / MT data)
- `srcB`  in  32  rt operand (multiplier / divisor)
- `cancel`  in  1  exception flush; aborts in-flight op
- `hiloRead`  in  1  MFHI/MFLO present in execute stage
- `busy`  out  1  op in flight
- `done`  out  1  one-cycle pulse in writeback cycle
- `stall`  out  1  busy & (start | hiloRead)
- `dinHi`, `dinLo`  out  32  HI/LO write data
- `hlWrite`  out  2  [1] write HI, [0] write LO

## Operation
- States: IDLE, MUL, DIV, FIX, WB.
- IDLE: `start` & ~`cancel` latches operands/op. MULT(U) -> MUL; DIV(U) with srcB != 0 -> DIV; DIV(U) with srcB == 0 -> WB with DIV0_HI/DIV0_LO; MTHI/MTLO -> WB with srcA in dinHi / dinLo; reserved op -> stays IDLE, no write.
- MUL/DIV: 32 iterations on magnitudes (signed ops take |srcA|, |srcB|; unsigned use raw), 5-bit counter; after 32nd iteration -> FIX.
- FIX: signed MULT negates 64-bit product if operand signs differ; signed DIV negates quotient if signs differ, remainder takes dividend's sign. Unsigned ops pass through. -> WB.
- WB: `hlWrite`=11 for mul/div (HI=product[63:32] or remainder, LO=product[31:0] or quotient); 10 for MTHI; 01 for MTLO. `done`=1. -> IDLE.
- 0x8000_0000 / -1 (DIV): LO=0x8000_0000, HI=0; no trap.
- `start` while busy ignored; upstream holds it under `stall`.
- `cancel` in any non-IDLE state: next state IDLE, no HI/LO write; in WB, `hlWrite` and `done` gated to 0 combinationally. `cancel` in IDLE blocks acceptance of same-cycle `start`.
- Reset: state IDLE, `busy`=0, `done`=0, `hlWrite`=00, `dinHi`=`dinLo`=0, counter 0. Reset mid-op discards the op.

## Timing
- Accept edge E0. MUL/DIV: iterations E1..E32, FIX at E33, WB cycle follows, HI/LO captured at E34; `busy` high from after E0 through WB cycle (34 cycles).
- MTHI/MTLO and divide-by-zero: WB cycle follows E0, HI/LO captured at E1; `busy` high 1 cycle.
- `dinHi`/`dinLo`/`hlWrite`/`done` valid only in WB; `hlWrite`=00 elsewhere.
- `stall` combinational; next op accepted at edge ending WB cycle is not allowed — IDLE required, so back-to-back accept at earliest on the edge after WB.

## Configuration
- `MULDIV_DIV_EN` defined: divider, DIV state and divide-by-zero path built as above.
- Undefined: DIV/DIVU accepted as reserved no-ops (stay IDLE, no write, no `done`); DIV state, divider datapath and DIV0 parameters unused.

## Test plan
- MULT srcA=0xFFFF_FFFD, srcB=5 -> at E34 `hlWrite`=11, dinHi=0xFFFF_FFFF, dinLo=0xFFFF_FFF1, `done` 1 cycle.
- MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> dinHi=0xFFFF_FFFE, dinLo=0x0000_0001 at E34.
- DIV -7/2 -> dinLo=0xFFFF_FFFD, dinHi=0xFFFF_FFFF; DIVU 100/7 -> dinLo=14, dinHi=2; DIVU x/0 -> DIV0 values at E1.
- MTHI 0x1234_5678 -> `hlWrite`=10, dinHi=0x1234_5678 at E1; MFHI (`hiloRead`) during MULT -> `stall`=1 until WB ends.
- `cancel` at cycle 10 of MULT -> `hlWrite` never nonzero, `busy`=0 next cycle, new MTLO accepted following cycle.
- `rst`=0 at cycle 20 of DIVU -> all outputs at reset values next edge, no write.
